// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-subset pipeline: ALU command encodings,
// register-shift type codes, NZCV bit positions and a rotate helper.
package arm_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CMD_W    = 4;
    localparam int unsigned SHOP_W   = 12;
    localparam int unsigned STATUS_W = 4;

    // NZCV bit positions inside the status register
    localparam int unsigned ST_N = 3;
    localparam int unsigned ST_Z = 2;
    localparam int unsigned ST_C = 1;
    localparam int unsigned ST_V = 0;

    typedef enum logic [CMD_W-1:0] {
        ALU_MOV = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_ADC = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SBC = 4'b0101,
        ALU_AND = 4'b0110,
        ALU_ORR = 4'b0111,
        ALU_EOR = 4'b1000,
        ALU_MVN = 4'b1001
    } alu_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    // Rotate right by 0..31; a shift by 32 yields zero, so amount 0 is identity
    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x,
                                                input logic [4:0]        amt);
        logic [5:0] lamt;
        lamt  = 6'd32 - {1'b0, amt};
        ror32 = (x >> amt) | (x << lamt);
    endfunction

endpackage

// File: rtl/val2_generator.sv
// Second-operand generator for the execute stage.
// Ports:
//   reg2         in  32  Rm value
//   shiftOperand in  12  inst[11:0]
//   imm          in  1   I bit
//   memAccess    in  1   load/store: use raw 12-bit offset
//   val2         out 32  selected operand 2 (combinational)
module val2_generator
    import arm_pkg::*;
(
    input  logic [DATA_W-1:0] reg2,
    input  logic [SHOP_W-1:0] shiftOperand,
    input  logic              imm,
    input  logic              memAccess,
    output logic [DATA_W-1:0] val2
);

    logic [4:0]        sh_amt;
    logic [4:0]        rot_amt;
    logic [DATA_W-1:0] imm8_ext;
    logic [DATA_W-1:0] reg_shifted;

    assign sh_amt   = shiftOperand[11:7];
    assign rot_amt  = {shiftOperand[11:8], 1'b0};
    assign imm8_ext = {24'b0, shiftOperand[7:0]};

    // Register shifter; amount 0 leaves reg2 untouched for every type
    always_comb begin
        reg_shifted = reg2;
        case (shift_e'(shiftOperand[6:5]))
            SH_LSL:  reg_shifted = reg2 << sh_amt;
            SH_LSR:  reg_shifted = reg2 >> sh_amt;
            SH_ASR:  reg_shifted = DATA_W'($signed(reg2) >>> sh_amt);
            SH_ROR:  reg_shifted = ror32(reg2, sh_amt);
            default: reg_shifted = reg2;
        endcase
    end

    // Memory offsets win over the I bit and are never rotated
    always_comb begin
        val2 = reg_shifted;
        if (memAccess) begin
            val2 = {20'b0, shiftOperand};
        end else if (imm) begin
            val2 = ror32(imm8_ext, rot_amt);
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch-target adder, and the architectural NZCV register.
// Ports:
//   clk, rst                      clock, async active-high reset
//   PC, imm24                     PC+4 and signed branch offset -> branchAddr
//   aluCmd, reg1, reg2, imm,
//   shiftOperand                  ALU command and operands -> aluRes
//   memRead, memWrite, wbEn,
//   branch, s, dest               decoded control bits
//   aluRes, branchAddr,
//   branchTaken, storeVal,
//   memReadOut, memWriteOut,
//   wbEnOut, destOut              combinational results / pass-throughs
//   status                        registered {N,Z,C,V}
module ex_stage
    import arm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   PC,
    input  logic [CMD_W-1:0]    aluCmd,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic                wbEn,
    input  logic                branch,
    input  logic                s,
    input  logic [DATA_W-1:0]   reg1,
    input  logic [DATA_W-1:0]   reg2,
    input  logic                imm,
    input  logic [SHOP_W-1:0]   shiftOperand,
    input  logic [23:0]         imm24,
    input  logic [3:0]          dest,
    output logic [DATA_W-1:0]   aluRes,
    output logic [DATA_W-1:0]   branchAddr,
    output logic                branchTaken,
    output logic [STATUS_W-1:0] status,
    output logic                memReadOut,
    output logic                memWriteOut,
    output logic                wbEnOut,
    output logic [3:0]          destOut,
    output logic [DATA_W-1:0]   storeVal
);

    logic [DATA_W-1:0]   val2;
    logic [DATA_W-1:0]   res;
    logic [DATA_W:0]     sum;
    logic                c_new;
    logic                v_new;
    logic                cmd_valid;
    logic                c_in;
    logic [STATUS_W-1:0] status_d;
    logic [STATUS_W-1:0] status_q;

    val2_generator u_val2 (
        .reg2         (reg2),
        .shiftOperand (shiftOperand),
        .imm          (imm),
        .memAccess    (memRead | memWrite),
        .val2         (val2)
    );

    assign c_in = status_q[ST_C];

    // ALU; subtraction is val1 + ~val2 + carry so carry-out is the no-borrow flag
    always_comb begin
        res       = '0;
        sum       = '0;
        c_new     = status_q[ST_C];
        v_new     = status_q[ST_V];
        cmd_valid = 1'b1;
        case (aluCmd)
            ALU_MOV: res = val2;
            ALU_MVN: res = ~val2;
            ALU_ADD, ALU_ADC: begin
                sum   = {1'b0, reg1} + {1'b0, val2}
                      + ((aluCmd == ALU_ADC) ? 33'(c_in) : 33'd0);
                res   = sum[DATA_W-1:0];
                c_new = sum[DATA_W];
                v_new = (reg1[31] == val2[31]) & (res[31] != reg1[31]);
            end
            ALU_SUB, ALU_SBC: begin
                sum   = {1'b0, reg1} + {1'b0, ~val2}
                      + ((aluCmd == ALU_SBC) ? 33'(c_in) : 33'd1);
                res   = sum[DATA_W-1:0];
                c_new = sum[DATA_W];
                v_new = (reg1[31] != val2[31]) & (res[31] != reg1[31]);
            end
            ALU_AND: res = reg1 & val2;
            ALU_ORR: res = reg1 | val2;
            ALU_EOR: res = reg1 ^ val2;
            default: cmd_valid = 1'b0;
        endcase
    end

    // Unknown commands leave every flag alone even when s is set
    always_comb begin
        status_d = status_q;
        if (cmd_valid) begin
            status_d[ST_N] = res[31];
            status_d[ST_Z] = (res == '0);
            status_d[ST_C] = c_new;
            status_d[ST_V] = v_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else if (s) begin
            status_q <= status_d;
        end
    end

    assign aluRes      = res;
    assign branchAddr  = PC + {{6{imm24[23]}}, imm24, 2'b00};
    assign branchTaken = branch;
    assign status      = status_q;
    assign memReadOut  = memRead;
    assign memWriteOut = memWrite;
    assign wbEnOut     = wbEn;
    assign destOut     = dest;
    assign storeVal    = reg2;

endmodule

// File: tb/tb_ex_stage.sv
// Directed, table-driven bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

    localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001, C_ADD = 4'b0010,
                           C_ADC = 4'b0011, C_SUB = 4'b0100, C_SBC = 4'b0101,
                           C_ORR = 4'b0111, C_EOR = 4'b1000, C_BAD = 4'b0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, reg1, reg2;
    logic [3:0]  aluCmd, dest;
    logic        memRead, memWrite, wbEn, branch, s, imm;
    logic [11:0] shiftOperand;
    logic [23:0] imm24;
    logic [31:0] aluRes, branchAddr, storeVal;
    logic        branchTaken, memReadOut, memWriteOut, wbEnOut;
    logic [3:0]  status, destOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .PC(PC), .aluCmd(aluCmd),
        .memRead(memRead), .memWrite(memWrite), .wbEn(wbEn), .branch(branch), .s(s),
        .reg1(reg1), .reg2(reg2), .imm(imm), .shiftOperand(shiftOperand),
        .imm24(imm24), .dest(dest),
        .aluRes(aluRes), .branchAddr(branchAddr), .branchTaken(branchTaken),
        .status(status), .memReadOut(memReadOut), .memWriteOut(memWriteOut),
        .wbEnOut(wbEnOut), .destOut(destOut), .storeVal(storeVal)
    );

    typedef struct packed {
        logic [3:0]  cmd;
        logic        mr, mw, im, s, br;
        logic [31:0] r1, r2;
        logic [11:0] so;
        logic [31:0] pc;
        logic [23:0] i24;
        logic [31:0] exp_res, exp_br;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic [3:0] cmd, logic mr, logic mw, logic im, logic sv,
                                logic br, logic [31:0] r1, logic [31:0] r2, logic [11:0] so,
                                logic [31:0] pc, logic [23:0] i24, logic [31:0] exp_res,
                                logic [31:0] exp_br, logic [3:0] exp_st);
        vec_t v;
        v.cmd = cmd; v.mr = mr; v.mw = mw; v.im = im; v.s = sv; v.br = br;
        v.r1 = r1; v.r2 = r2; v.so = so; v.pc = pc; v.i24 = i24;
        v.exp_res = exp_res; v.exp_br = exp_br; v.exp_st = exp_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        PC = '0; reg1 = '0; reg2 = '0; aluCmd = C_BAD; dest = '0;
        memRead = 0; memWrite = 0; wbEn = 0; branch = 0; s = 0; imm = 0;
        shiftOperand = '0; imm24 = '0;
    endtask

    initial begin
        //                cmd    mr mw im s br r1            r2            so      pc        i24        exp_res       exp_br        st
        vecs[0]  = mk(C_MOV, 0, 0, 1, 0, 0, 32'h0,        32'h0,        12'h2FF, 32'h0,    24'h0,     32'hF000000F, 32'h0,        4'b0000);
        vecs[1]  = mk(C_ADD, 0, 0, 1, 1, 0, 32'h7FFFFFFF, 32'h0,        12'h001, 32'h0,    24'h0,     32'h80000000, 32'h0,        4'b1001);
        vecs[2]  = mk(C_EOR, 0, 0, 1, 1, 0, 32'hFF,       32'h0,        12'h00F, 32'h0,    24'h0,     32'h000000F0, 32'h0,        4'b0001);
        vecs[3]  = mk(C_SUB, 0, 0, 1, 1, 0, 32'h5,        32'h0,        12'h005, 32'h0,    24'h0,     32'h0,        32'h0,        4'b0110);
        vecs[4]  = mk(C_ADC, 0, 0, 1, 0, 0, 32'h1,        32'h0,        12'h002, 32'h0,    24'h0,     32'h4,        32'h0,        4'b0110);
        vecs[5]  = mk(C_SUB, 0, 0, 1, 1, 0, 32'h2,        32'h0,        12'h005, 32'h0,    24'h0,     32'hFFFFFFFD, 32'h0,        4'b1000);
        vecs[6]  = mk(C_SBC, 0, 0, 1, 0, 0, 32'h5,        32'h0,        12'h002, 32'h0,    24'h0,     32'h2,        32'h0,        4'b1000);
        vecs[7]  = mk(C_MOV, 0, 0, 0, 0, 0, 32'h0,        32'h80000000, 12'h240, 32'h0,    24'h0,     32'hF8000000, 32'h0,        4'b1000);
        vecs[8]  = mk(C_MOV, 0, 0, 0, 0, 0, 32'h0,        32'h80000000, 12'h060, 32'h0,    24'h0,     32'h80000000, 32'h0,        4'b1000);
        vecs[9]  = mk(C_MOV, 0, 0, 0, 0, 0, 32'h0,        32'hF0000000, 12'hFA0, 32'h0,    24'h0,     32'h1,        32'h0,        4'b1000);
        vecs[10] = mk(C_ORR, 0, 0, 0, 0, 0, 32'h0F,       32'h0F,       12'h400, 32'h0,    24'h0,     32'hF0F,      32'h0,        4'b1000);
        vecs[11] = mk(C_ADD, 1, 0, 0, 0, 0, 32'h100,      32'h1234,     12'hFFC, 32'h1000, 24'h000003, 32'h10FC,     32'h100C,     4'b1000);
        vecs[12] = mk(C_ADD, 0, 1, 1, 0, 0, 32'h0,        32'hCAFE,     12'hFFC, 32'h0,    24'h0,     32'hFFC,      32'h0,        4'b1000);
        vecs[13] = mk(C_BAD, 0, 0, 1, 1, 1, 32'h7,        32'h0,        12'h001, 32'h20,   24'hFFFFFE, 32'h0,        32'h18,       4'b1000);
        vecs[14] = mk(C_ADD, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 32'h0,        12'h001, 32'h0,    24'h0,     32'h0,        32'h0,        4'b0110);
        vecs[15] = mk(C_MVN, 0, 0, 1, 1, 0, 32'h0,        32'h0,        12'h000, 32'h0,    24'h0,     32'hFFFFFFFF, 32'h0,        4'b1010);
        vecs[16] = mk(C_ADC, 0, 0, 1, 1, 0, 32'h0,        32'h0,        12'h000, 32'h0,    24'h0,     32'h1,        32'h0,        4'b0000);
        vecs[17] = mk(C_SBC, 0, 0, 1, 1, 0, 32'h0,        32'h0,        12'h000, 32'h0,    24'h0,     32'hFFFFFFFF, 32'h0,        4'b1000);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_status", 32'(status), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            aluCmd = vecs[i].cmd; memRead = vecs[i].mr; memWrite = vecs[i].mw;
            imm = vecs[i].im; s = vecs[i].s; branch = vecs[i].br;
            reg1 = vecs[i].r1; reg2 = vecs[i].r2; shiftOperand = vecs[i].so;
            PC = vecs[i].pc; imm24 = vecs[i].i24;
            dest = 4'(i); wbEn = (i % 2) == 1;
            #1;
            check($sformatf("v%0d_aluRes", i), aluRes, vecs[i].exp_res);
            check($sformatf("v%0d_branchAddr", i), branchAddr, vecs[i].exp_br);
            check($sformatf("v%0d_passthru", i),
                  {storeVal[27:0], destOut, branchTaken, memReadOut, memWriteOut, wbEnOut},
                  {vecs[i].r2[27:0], 4'(i), vecs[i].br, vecs[i].mr, vecs[i].mw, 1'((i % 2) == 1)});
            @(posedge clk);
            #1 check($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].exp_st));
        end

        // Asynchronous reset mid-cycle clears status before the next edge
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1 check("async_reset_clear", 32'(status), 32'h0);

        // Reset held with an ADDS in EX: two edges, no update; combinational path still live
        aluCmd = C_ADD; imm = 1; shiftOperand = 12'h001; reg1 = 32'h7FFFFFFF; s = 1;
        #1 check("reset_comb_aluRes", aluRes, 32'h80000000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 check($sformatf("reset_hold_edge%0d", k), 32'(status), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("post_reset_update", 32'(status), 32'h9);

        // s=0 holds status across an edge
        @(negedge clk);
        aluCmd = C_SUB; shiftOperand = 12'h001; reg1 = 32'h1; s = 0;
        @(posedge clk);
        #1 check("s0_hold", 32'(status), 32'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
